// File: rtl/z80_io_bridge_pkg.sv
// Shared constants for the Z80 I/O bridge: default VDP port window,
// FSM state encoding and the port-window decode helper.
package z80_io_bridge_pkg;

  // Default base of the 4-port VDP window (ports 0x98..0x9B)
  localparam logic [7:0] VDP_IO_BASE = 8'h98;

  // Bridge FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Port window hit: the upper six address bits select the window
  function automatic logic port_hit(input logic [5:0] addr_hi, input logic [5:0] base_hi);
    return (addr_hi == base_hi);
  endfunction

endpackage

// File: rtl/z80_io_bridge_strobe_sync.sv
// Multi-stage synchroniser for an asynchronous active-low Z80 strobe.
// Provides the synchronised level and a registered falling-edge pulse.
// Everything resets to the inactive (high) level so that a reset release
// never fabricates an edge.
module io_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe_n,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              fall_r;

  // Shift the raw strobe through the synchroniser chain and register the falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {STAGES{1'b1}};
      prev_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], strobe_n};
      prev_r <= sync_r[STAGES-1];
      fall_r <= prev_r & ~sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign fall  = fall_r;

endmodule

// File: rtl/z80_io_bridge.sv
// Z80 I/O-bus front end for the VDP. Decodes the port window, synchronises
// the IORQ read/write strobes into the pixel clock domain and issues one
// held request per Z80 bus cycle. Read data is returned on cd while the
// read strobe is low; a stalled request is abandoned after ACK_TIMEOUT
// clocks and flagged on the sticky bus_err output.
module z80_io_bridge
  import z80_io_bridge_pkg::*;
#(
  parameter logic [7:0] IO_BASE     = VDP_IO_BASE,
  parameter int         SYNC_STAGES = 2,
  parameter int         ACK_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] A,
  input  logic       rd_iorq_n,
  input  logic       wr_iorq_n,
  inout  wire  [7:0] cd,
  output logic       cs_n,
  output logic       CpuReq,
  output logic       CpuWrt,
  output logic [1:0] CpuAdr,
  output logic [7:0] CpuDbo,
  input  logic       CpuAck,
  input  logic [7:0] CpuDbi,
  output logic       bus_err
);

  localparam int                CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_MAX = CNT_W'(ACK_TIMEOUT);

  logic [7:0]       a_r;
  logic [7:0]       cd_r;
  logic [1:0]       state_r;
  logic             req_r;
  logic             wrt_r;
  logic [1:0]       adr_r;
  logic [7:0]       dbo_r;
  logic [7:0]       rd_data_r;
  logic             cd_oe_r;
  logic             bus_err_r;
  logic [CNT_W-1:0] cnt_r;

  logic rd_s;
  logic wr_s;
  logic rd_fall_s;
  logic wr_fall_s;
  logic a_hit_s;
  logic rd_start_s;
  logic wr_start_s;
  logic cd_drive_s;

  io_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_n (rd_iorq_n),
    .level    (rd_s),
    .fall     (rd_fall_s)
  );

  io_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .strobe_n (wr_iorq_n),
    .level    (wr_s),
    .fall     (wr_fall_s)
  );

  // Transceiver enable follows the raw bus so it opens as soon as the Z80 strobes
  assign cs_n = ~((~rd_iorq_n | ~wr_iorq_n) & port_hit(A[7:2], IO_BASE[7:2]));

  // An access starts on a strobe edge only if the other strobe is idle; both low is illegal
  assign a_hit_s    = port_hit(a_r[7:2], IO_BASE[7:2]);
  assign rd_start_s = rd_fall_s & a_hit_s & wr_s;
  assign wr_start_s = wr_fall_s & a_hit_s & rd_s;

  // Drive the bus only while our read is still in progress on the raw strobe
  assign cd_drive_s = cd_oe_r & ~rd_iorq_n;
  assign cd         = cd_drive_s ? rd_data_r : 8'hzz;

  // Sample the Z80 address and data buses every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r  <= 8'h00;
      cd_r <= 8'h00;
    end else begin
      a_r  <= A;
      cd_r <= cd;
    end
  end

  // Request FSM: one request per bus cycle, held until ack or timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      req_r     <= 1'b0;
      wrt_r     <= 1'b0;
      adr_r     <= 2'b00;
      dbo_r     <= 8'h00;
      rd_data_r <= 8'hFF;
      cd_oe_r   <= 1'b0;
      bus_err_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_start_s) begin
            dbo_r   <= cd_r;
            adr_r   <= a_r[1:0];
            wrt_r   <= 1'b1;
            req_r   <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_REQ;
          end else if (rd_start_s) begin
            adr_r   <= a_r[1:0];
            wrt_r   <= 1'b0;
            req_r   <= 1'b1;
            cd_oe_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (CpuAck) begin
            req_r <= 1'b0;
            if (!wrt_r) begin
              rd_data_r <= CpuDbi;
            end
            state_r <= ST_HOLD;
          end else if (cnt_r == TMO_MAX) begin
            req_r     <= 1'b0;
            bus_err_r <= 1'b1;
            rd_data_r <= 8'hFF;
            state_r   <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (rd_s && wr_s) begin
            cd_oe_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          cd_oe_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign CpuReq  = req_r;
  assign CpuWrt  = wrt_r;
  assign CpuAdr  = adr_r;
  assign CpuDbo  = dbo_r;
  assign bus_err = bus_err_r;

endmodule
